// File: rtl/stage_transition_ctrl_if.sv
// Door-hit bundle from the two per-stage door detectors into the stage transition controller.
interface stage_transition_ctrl_if #(
  parameter int STAGE_W = 5
);
  logic               doorHit0;
  logic               doorHit1;
  logic [STAGE_W-1:0] newStage0;
  logic [STAGE_W-1:0] newStage1;
  logic [31:0]        newPosX0;
  logic [31:0]        newPosX1;

  modport master (
    output doorHit0, doorHit1, newStage0, newStage1, newPosX0, newPosX1
  );

  modport slave (
    input  doorHit0, doorHit1, newStage0, newStage1, newPosX0, newPosX1
  );
endinterface

// File: rtl/stage_transition_ctrl.sv
// Sequenced stage change: fade out, load new stage and spawn X, fade in, then a door lockout.
// Owns the current stage code and the RGB brightness level.
module stage_transition_ctrl #(
  parameter int STAGE_W         = 5,
  parameter int NUM_STAGES      = 16,
  parameter int INIT_STAGE      = 0,
  parameter int INIT_POSX       = 32,
  parameter int STEP_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frameTick,
  stage_transition_ctrl_if.slave  door,
  output logic [STAGE_W-1:0]      stageCode,
  output logic [31:0]             charPosX,
  output logic                    charLoad,
  output logic [2:0]              brightness,
  output logic                    busy,
  output logic                    badDoor
);

  localparam int CNT_MAX = (STEP_FRAMES > COOLDOWN_FRAMES) ? STEP_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   STEP_LAST     = CNT_W'(STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CD_LAST       = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [STAGE_W:0]   NUM_STAGES_L  = (STAGE_W + 1)'(NUM_STAGES);
  localparam logic [STAGE_W-1:0] INIT_STAGE_L  = STAGE_W'(INIT_STAGE);
  localparam logic [31:0]        INIT_POSX_L   = 32'(INIT_POSX);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_LOAD     = 3'd2,
    S_FADE_IN  = 3'd3,
    S_COOLDOWN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bright_q, bright_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [31:0]        posx_q, posx_d;
  logic [STAGE_W-1:0] tgt_stage_q, tgt_stage_d;
  logic [31:0]        tgt_posx_q, tgt_posx_d;
  logic               char_load_q, char_load_d;
  logic               busy_q, busy_d;
  logic               bad_door_q, bad_door_d;

  logic               hit_s;
  logic               bad_s;
  logic [STAGE_W-1:0] sel_stage_s;
  logic [31:0]        sel_posx_s;
  logic               step_s;
  logic               cd_done_s;

  // Door 0 has priority when both doors report a hit in the same cycle.
  assign hit_s       = door.doorHit0 | door.doorHit1;
  assign sel_stage_s = door.doorHit0 ? door.newStage0 : door.newStage1;
  assign sel_posx_s  = door.doorHit0 ? door.newPosX0  : door.newPosX1;
  assign bad_s       = ({1'b0, sel_stage_s} >= NUM_STAGES_L);
  assign step_s      = frameTick && (cnt_q == STEP_LAST);
  assign cd_done_s   = frameTick && (cnt_q == CD_LAST);

  // Next-state, frame counter, brightness ramp and stage load decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bright_d    = bright_q;
    stage_d     = stage_q;
    posx_d      = posx_q;
    tgt_stage_d = tgt_stage_q;
    tgt_posx_d  = tgt_posx_q;
    char_load_d = 1'b0;
    bad_door_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A tick arriving with the hit is deliberately not counted.
        cnt_d = {CNT_W{1'b0}};
        if (hit_s && bad_s) begin
          bad_door_d = 1'b1;
        end else if (hit_s) begin
          tgt_stage_d = sel_stage_s;
          tgt_posx_d  = sel_posx_s;
          state_d     = S_FADE_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FADE_OUT: begin
        if (step_s) begin
          cnt_d    = {CNT_W{1'b0}};
          bright_d = (bright_q != 3'd0) ? (bright_q - 3'd1) : 3'd0;
          if (bright_q <= 3'd1) begin
            // Stage and X become visible together with the load strobe.
            state_d     = S_LOAD;
            stage_d     = tgt_stage_q;
            posx_d      = tgt_posx_q;
            char_load_d = 1'b1;
          end else begin
            state_d = S_FADE_OUT;
          end
        end else if (frameTick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LOAD: begin
        cnt_d    = {CNT_W{1'b0}};
        bright_d = 3'd0;
        state_d  = S_FADE_IN;
      end
      S_FADE_IN: begin
        if (step_s) begin
          cnt_d    = {CNT_W{1'b0}};
          bright_d = (bright_q != 3'd7) ? (bright_q + 3'd1) : 3'd7;
          if (bright_q >= 3'd6) begin
            state_d = S_COOLDOWN;
          end else begin
            state_d = S_FADE_IN;
          end
        end else if (frameTick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_COOLDOWN: begin
        if (cd_done_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
        end else if (frameTick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bright_q    <= 3'd7;
      stage_q     <= INIT_STAGE_L;
      posx_q      <= INIT_POSX_L;
      tgt_stage_q <= {STAGE_W{1'b0}};
      tgt_posx_q  <= 32'd0;
      char_load_q <= 1'b0;
      busy_q      <= 1'b0;
      bad_door_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bright_q    <= bright_d;
      stage_q     <= stage_d;
      posx_q      <= posx_d;
      tgt_stage_q <= tgt_stage_d;
      tgt_posx_q  <= tgt_posx_d;
      char_load_q <= char_load_d;
      busy_q      <= busy_d;
      bad_door_q  <= bad_door_d;
    end
  end

  assign stageCode  = stage_q;
  assign charPosX   = posx_q;
  assign charLoad   = char_load_q;
  assign brightness = bright_q;
  assign busy       = busy_q;
  assign badDoor    = bad_door_q;

endmodule

// File: tb/tb_stage_transition_ctrl.sv
// Directed bench for stage_transition_ctrl with STEP_FRAMES=2, COOLDOWN_FRAMES=4.
module tb_stage_transition_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frameTick;
  logic [4:0]  stageCode;
  logic [31:0] charPosX;
  logic        charLoad;
  logic [2:0]  brightness;
  logic        busy;
  logic        badDoor;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  logic [4:0]  ld_stage = 5'd0;
  logic [31:0] ld_posx = 32'd0;

  stage_transition_ctrl_if #(.STAGE_W(5)) door_if_i ();

  stage_transition_ctrl #(
    .STAGE_W(5), .NUM_STAGES(16), .INIT_STAGE(0), .INIT_POSX(32),
    .STEP_FRAMES(2), .COOLDOWN_FRAMES(4)
  ) dut (
    .clk(clk), .reset(reset), .frameTick(frameTick), .door(door_if_i),
    .stageCode(stageCode), .charPosX(charPosX), .charLoad(charLoad),
    .brightness(brightness), .busy(busy), .badDoor(badDoor)
  );

  always #5 clk = ~clk;

  // Record every load strobe and the values presented with it.
  always @(negedge clk) begin
    if (charLoad === 1'b1) begin
      load_cnt <= load_cnt + 1;
      ld_stage <= stageCode;
      ld_posx  <= charPosX;
    end
  end

  typedef struct {
    logic        hit0;
    logic        hit1;
    logic [4:0]  ns0;
    logic [4:0]  ns1;
    logic [31:0] px0;
    logic [31:0] px1;
    logic        exp_bad;
    logic [4:0]  exp_stage;
    logic [31:0] exp_posx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frameTick = 1'b1;
    cyc();
    frameTick = 1'b0;
    cyc();
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      frame();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int ld0;
    reset = 1'b1;
    frameTick = 1'b0;
    door_if_i.doorHit0 = 1'b0;
    door_if_i.doorHit1 = 1'b0;
    door_if_i.newStage0 = 5'd0;
    door_if_i.newStage1 = 5'd0;
    door_if_i.newPosX0 = 32'd0;
    door_if_i.newPosX1 = 32'd0;

    vecs[0] = '{1'b1, 1'b1, 5'd2,  5'd5,  32'd100,  32'd200, 1'b0, 5'd2,  32'd100};
    vecs[1] = '{1'b1, 1'b0, 5'd20, 5'd3,  32'd111,  32'd222, 1'b1, 5'd2,  32'd100};
    vecs[2] = '{1'b0, 1'b1, 5'd20, 5'd9,  32'd333,  32'd500, 1'b0, 5'd9,  32'd500};
    vecs[3] = '{1'b1, 1'b0, 5'd9,  5'd31, 32'd64,   32'd700, 1'b0, 5'd9,  32'd64};
    vecs[4] = '{1'b0, 1'b1, 5'd1,  5'd16, 32'd12,   32'd13,  1'b1, 5'd9,  32'd64};
    vecs[5] = '{1'b1, 1'b0, 5'd15, 5'd0,  32'd1023, 32'd0,   1'b0, 5'd15, 32'd1023};

    // Reset values, then a long idle stretch.
    cyc();
    cyc();
    chk("rst_stage", int'(stageCode), 0);
    chk("rst_posx", int'(charPosX), 32);
    chk("rst_bright", int'(brightness), 7);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bad", int'(badDoor), 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) frame();
    chk("idle_stage", int'(stageCode), 0);
    chk("idle_posx", int'(charPosX), 32);
    chk("idle_bright", int'(brightness), 7);
    chk("idle_busy", int'(busy), 0);
    chk("idle_loads", load_cnt, 0);

    // Full transition through door 1 with per-tick brightness tracking.
    door_if_i.newStage1 = 5'd3;
    door_if_i.newPosX1 = 32'd960;
    door_if_i.doorHit1 = 1'b1;
    cyc();
    door_if_i.doorHit1 = 1'b0;
    chk("fade_busy_start", int'(busy), 1);
    ld0 = load_cnt;
    for (int k = 1; k <= 14; k++) begin
      frame();
      chk($sformatf("fade_out_%0d", k), int'(brightness), 7 - k / 2);
    end
    chk("fade_load_cnt", load_cnt - ld0, 1);
    chk("fade_load_stage", int'(ld_stage), 3);
    chk("fade_load_posx", int'(ld_posx), 960);
    for (int j = 1; j <= 14; j++) begin
      frame();
      chk($sformatf("fade_in_%0d", j), int'(brightness), j / 2);
    end
    for (int c = 1; c <= 4; c++) begin
      frame();
      chk($sformatf("cooldown_busy_%0d", c), int'(busy), (c < 4) ? 1 : 0);
    end
    chk("fade_stage", int'(stageCode), 3);
    chk("fade_posx", int'(charPosX), 960);
    chk("fade_load_total", load_cnt - ld0, 1);

    // Table: door selection, priority, invalid targets, same-stage target.
    for (int v = 0; v < 6; v++) begin
      ld0 = load_cnt;
      door_if_i.newStage0 = vecs[v].ns0;
      door_if_i.newStage1 = vecs[v].ns1;
      door_if_i.newPosX0 = vecs[v].px0;
      door_if_i.newPosX1 = vecs[v].px1;
      door_if_i.doorHit0 = vecs[v].hit0;
      door_if_i.doorHit1 = vecs[v].hit1;
      cyc();
      door_if_i.doorHit0 = 1'b0;
      door_if_i.doorHit1 = 1'b0;
      chk($sformatf("vec%0d_bad", v), int'(badDoor), int'(vecs[v].exp_bad));
      chk($sformatf("vec%0d_busy", v), int'(busy), vecs[v].exp_bad ? 0 : 1);
      cyc();
      chk($sformatf("vec%0d_bad_off", v), int'(badDoor), 0);
      run_idle();
      chk($sformatf("vec%0d_stage", v), int'(stageCode), int'(vecs[v].exp_stage));
      chk($sformatf("vec%0d_posx", v), int'(charPosX), int'(vecs[v].exp_posx));
      chk($sformatf("vec%0d_bright", v), int'(brightness), 7);
      chk($sformatf("vec%0d_loads", v), load_cnt - ld0, vecs[v].exp_bad ? 0 : 1);
    end

    // Target latched at the hit; a re-hit with new inputs during fade-out is ignored.
    ld0 = load_cnt;
    door_if_i.newStage0 = 5'd4;
    door_if_i.newPosX0 = 32'd40;
    door_if_i.doorHit0 = 1'b1;
    cyc();
    door_if_i.doorHit0 = 1'b0;
    for (int i = 0; i < 3; i++) frame();
    door_if_i.newStage0 = 5'd7;
    door_if_i.newPosX0 = 32'd77;
    door_if_i.doorHit0 = 1'b1;
    cyc();
    door_if_i.doorHit0 = 1'b0;
    cyc();
    chk("latch_no_bad", int'(badDoor), 0);
    run_idle();
    chk("latch_stage", int'(stageCode), 4);
    chk("latch_posx", int'(charPosX), 40);
    for (int i = 0; i < 5; i++) frame();
    chk("latch_no_retrigger", int'(busy), 0);
    chk("latch_loads", load_cnt - ld0, 1);

    // Hit held through cooldown starts a new transition on the first idle cycle.
    door_if_i.newStage0 = 5'd7;
    door_if_i.newPosX0 = 32'd70;
    door_if_i.doorHit0 = 1'b1;
    cyc();
    door_if_i.doorHit0 = 1'b0;
    for (int i = 0; i < 28; i++) frame();
    chk("hold_cd_bright", int'(brightness), 7);
    chk("hold_cd_busy", int'(busy), 1);
    door_if_i.newStage0 = 5'd11;
    door_if_i.newPosX0 = 32'd110;
    door_if_i.doorHit0 = 1'b1;
    for (int i = 0; i < 3; i++) frame();
    chk("hold_cd_still_busy", int'(busy), 1);
    frameTick = 1'b1;
    cyc();
    frameTick = 1'b0;
    chk("hold_idle_busy", int'(busy), 0);
    chk("hold_idle_stage", int'(stageCode), 7);
    chk("hold_idle_posx", int'(charPosX), 70);
    cyc();
    chk("hold_restart_busy", int'(busy), 1);
    door_if_i.doorHit0 = 1'b0;
    run_idle();
    chk("hold_stage", int'(stageCode), 11);
    chk("hold_posx", int'(charPosX), 110);

    // Tick coincident with the hit is not counted; reset mid fade-in.
    door_if_i.newStage1 = 5'd6;
    door_if_i.newPosX1 = 32'd600;
    door_if_i.doorHit1 = 1'b1;
    frameTick = 1'b1;
    cyc();
    door_if_i.doorHit1 = 1'b0;
    frameTick = 1'b0;
    chk("rmid_busy", int'(busy), 1);
    frame();
    chk("rmid_tick_skip", int'(brightness), 7);
    frame();
    chk("rmid_first_step", int'(brightness), 6);
    for (int i = 0; i < 12; i++) frame();
    chk("rmid_black", int'(brightness), 0);
    chk("rmid_loaded", int'(stageCode), 6);
    for (int i = 0; i < 6; i++) frame();
    chk("rmid_bright3", int'(brightness), 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rmid_rst_bright", int'(brightness), 7);
    chk("rmid_rst_stage", int'(stageCode), 0);
    chk("rmid_rst_posx", int'(charPosX), 32);
    chk("rmid_rst_busy", int'(busy), 0);
    chk("rmid_rst_load", int'(charLoad), 0);
    for (int i = 0; i < 3; i++) frame();
    chk("rmid_post_busy", int'(busy), 0);
    chk("rmid_post_bright", int'(brightness), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_transition_ctrl.md
Name: stage_transition_ctrl

Overview:
- Consumes the door-hit interface of the two per-stage door detectors: trigger pulse, next-stage code and spawn X per door.
- Performs the stage change as a sequenced transition: fade out, one-cycle load of new stage code and character X, fade in, then a cooldown during which door hits are ignored.
- Owns the current stageCode register that feeds the door detectors, the tile renderer and the sprite logic, plus a brightness level for the RGB output stage.

Parameters:
- STAGE_W, 5, width of stage code.
- NUM_STAGES, 16, number of valid stages; codes >= this are rejected.
- INIT_STAGE, 0, stage code after reset.
- INIT_POSX, 32, character X after reset, in pixels.
- STEP_FRAMES, 4, frame ticks per brightness step.
- COOLDOWN_FRAMES, 30, frame ticks of door lockout after fade-in.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frameTick  in  1  one-cycle pulse per video frame (end of vsync).
- doorHit0  in  1  door 0 hit; level or pulse, sampled each clk.
- doorHit1  in  1  door 1 hit.
- newStage0  in  STAGE_W  target stage for door 0.
- newStage1  in  STAGE_W  target stage for door 1.
- newPosX0  in  32  spawn X for door 0, in pixels.
- newPosX1  in  32  spawn X for door 1.
- stageCode  out  STAGE_W  current stage; consumers zero-extend.
- charPosX  out  32  character X to load into the character module.
- charLoad  out  1  one-cycle strobe: character module loads charPosX.
- brightness  out  3  0 = black, 7 = full; RGB stage gates colour by this.
- busy  out  1  high in every state except IDLE.
- badDoor  out  1  one-cycle pulse when a hit targets an invalid stage.

Behaviour:
- Reset:
  - Synchronous, active-high; wins over everything, including mid-transition.
  - Values: state = IDLE, stageCode = INIT_STAGE, charPosX = INIT_POSX, brightness = 7, charLoad = 0, busy = 0, badDoor = 0.
  - Frame counter = 0; latched target cleared.
- States: IDLE, FADE_OUT, LOAD, FADE_IN, COOLDOWN.
- IDLE:
  - On a clk edge with doorHit0 | doorHit1, select the door; door0 wins if both are high.
  - If the selected newStage >= NUM_STAGES: pulse badDoor for 1 cycle and stay in IDLE.
  - Otherwise latch the selected newStage/newPosX into internal target registers, clear the frame counter, go to FADE_OUT; busy = 1 from the next cycle.
  - Latched target is immune to later changes on the newStage/newPosX inputs.
- Frame counter:
  - Increments only on frameTick.
  - When it equals STEP_FRAMES-1 on a frameTick, one step fires and the counter clears.
- FADE_OUT:
  - Each step decrements brightness by 1.
  - On the step that takes brightness 1 -> 0, go to LOAD next cycle.
  - Total duration is 7*STEP_FRAMES frame ticks.
- LOAD (exactly 1 cycle):
  - stageCode <= target stage, charPosX <= target X, charLoad = 1 for this cycle only.
  - Clear the counter; go to FADE_IN.
  - brightness stays 0 through LOAD.
- FADE_IN:
  - Each step increments brightness by 1.
  - On reaching 7, go to COOLDOWN with the counter cleared.
- COOLDOWN:
  - Count COOLDOWN_FRAMES frameTicks.
  - On the tick where count == COOLDOWN_FRAMES-1, return to IDLE; busy falls the same cycle the state becomes IDLE.
- Door hits outside IDLE are ignored entirely; no queuing and no badDoor.
- A hit still held on the first IDLE cycle after cooldown starts a new transition.
- brightness never wraps: it saturates at 0 in FADE_OUT and at 7 in FADE_IN.
- frameTick concurrent with a door hit in IDLE: that tick is not counted.
- STEP_FRAMES = 1 is legal: one step per tick.
- Same-stage target (newStage == stageCode) is legal and runs the full sequence.

Test Plan:
- Reset, then idle for 100 frameTicks -> stageCode = 0, charPosX = 32, brightness = 7, busy = 0, charLoad never asserted.
- STEP_FRAMES = 2, COOLDOWN_FRAMES = 4; pulse doorHit1 with newStage1 = 3, newPosX1 = 960 -> brightness 7..0 over 14 ticks; one charLoad cycle with stageCode = 3, charPosX = 960; brightness 0..7 over 14 ticks; busy drops after 4 more ticks.
- doorHit0 and doorHit1 high together (newStage0 = 2, newStage1 = 5) -> stageCode ends at 2.
- newStage0 = 20 with doorHit0 pulse -> badDoor high exactly 1 cycle, state stays IDLE, stageCode unchanged.
- Change newStage0 from 4 to 7 and re-pulse doorHit0 during FADE_OUT -> final stageCode = 4, no second transition; doorHit0 held during COOLDOWN -> new transition begins on the first IDLE cycle.
- Assert reset mid-FADE_IN at brightness 3 -> next cycle brightness = 7, stageCode = 0, charPosX = 32, busy = 0.
